score_digit_source: RTL and testbench

Sequential binary-to-BCD source that turns the game's binary score into per-digit values for the on-screen 3×5 block-digit glyph renderers. It sits between score/combo logic and the digit renderers' 4-bit `num` inputs. It converts a loaded score with an iterative shift-add-3 (double-dabble) engine and holds the result in a double-buffered display register, so a frame never shows a half-converted value. Renderers read the result back by digit index.

---
 rtl/score_digit_source_pkg.sv | 26 ++
 rtl/score_digit_source_if.sv | 43 ++++
 rtl/score_digit_source_adj.sv | 12 +
 rtl/score_digit_source.sv | 179 +++++++++++++++++
 tb/tb_score_digit_source.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/score_digit_source_pkg.sv
// Shared types and constants for the score-to-BCD display source.
// Holds the engine state encoding, the BCD digit type and the overflow limit helper.
package score_pkg;

    localparam int DEF_BIN_WIDTH = 16;
    localparam int DEF_DIGITS    = 5;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Largest value representable in 'digits' decimal digits, i.e. 10^digits - 1.
    function automatic logic [63:0] max_score(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/score_digit_source_if.sv
// Bus between score logic / glyph renderers and score_digit_source.
// The master drives the score load and digit select; the slave returns digit and status.
interface score_digit_source_if #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
);
    localparam int SEL_W = $clog2(DIGITS) + 1;

    logic [BIN_WIDTH-1:0] score_in;
    logic                 load;
    logic [SEL_W-1:0]     digit_sel;
    logic [3:0]           digit_out;
    logic                 digit_blank;
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic                 overflow;

    modport master (
        output score_in,
        output load,
        output digit_sel,
        input  digit_out,
        input  digit_blank,
        input  busy,
        input  done,
        input  valid,
        input  overflow
    );

    modport slave (
        input  score_in,
        input  load,
        input  digit_sel,
        output digit_out,
        output digit_blank,
        output busy,
        output done,
        output valid,
        output overflow
    );

endinterface

// File: rtl/score_digit_source_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import score_pkg::*;
(
    input  bcd_t i_nib,
    output bcd_t o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/score_digit_source.sv
// Iterative binary-to-BCD converter with a double-buffered display register and digit read port.
// Optional macro SCORE_LEADING_BLANK_EN blanks leading zero digits above the most significant nonzero one.
module score_digit_source
    import score_pkg::*;
#(
    parameter int BIN_WIDTH = DEF_BIN_WIDTH,
    parameter int DIGITS    = DEF_DIGITS
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    score_digit_source_if.slave   bus
);

    localparam int          SEL_W = $clog2(DIGITS) + 1;
    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX   = max_score(DIGITS);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'd9}};

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_start;
    logic                 w_shift;
    logic                 w_commit;
    logic                 w_last;

    logic [BIN_WIDTH-1:0] r_bin;
    logic [BIN_WIDTH-1:0] r_pend_val;
    logic                 r_pend;
    logic [BIN_WIDTH-1:0] w_capture;

    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     r_disp;
    logic [CNT_W-1:0]     r_cnt;

    logic                 r_big;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_ovf;

    bcd_t                 w_disp_arr [DIGITS];
    bcd_t                 w_digit;
    logic                 w_blank;
`ifdef SCORE_LEADING_BLANK_EN
    logic                 w_zero_run;
`endif

    assign w_capture = bus.load ? bus.score_in : r_pend_val;
    assign w_last    = (r_cnt == CNT_W'(BIN_WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load || r_pend) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A load arriving while the engine runs is parked here; the newest one wins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else if (bus.load && (r_state != IDLE)) begin
            r_pend     <= 1'b1;
            r_pend_val <= bus.score_in;
        end else if (w_start) begin
            r_pend     <= 1'b0;
        end
    end

    // ---------------- shift-add-3 engine ----------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_nib (r_bcd[4*gi +: 4]),
            .o_nib (w_bcd_adj[4*gi +: 4])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_big <= 1'b0;
        end else if (w_start) begin
            r_bin <= w_capture;
            r_bcd <= '0;
            r_cnt <= '0;
            r_big <= (64'(w_capture) > MAX);
        end else if (w_shift) begin
            r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
            r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ---------------- display buffer ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_disp  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_disp  <= r_big ? ALL_NINES : r_bcd;
                r_ovf   <= r_big;
                r_valid <= 1'b1;
            end
        end
    end

    // ---------------- read port ----------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_disp
        assign w_disp_arr[gi] = r_disp[4*gi +: 4];
    end

    // Walk from the top digit down so the leading-zero run is known at each index.
    always_comb begin
        w_digit = '0;
        w_blank = 1'b1;
`ifdef SCORE_LEADING_BLANK_EN
        w_zero_run = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SCORE_LEADING_BLANK_EN
            w_zero_run = w_zero_run && (w_disp_arr[i] == 4'd0);
`endif
            if (bus.digit_sel == SEL_W'(i)) begin
                w_digit = w_disp_arr[i];
`ifdef SCORE_LEADING_BLANK_EN
                w_blank = (i != 0) && w_zero_run;
`else
                w_blank = 1'b0;
`endif
            end
        end
    end

    assign bus.digit_out   = w_digit;
    assign bus.digit_blank = w_blank;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.valid       = r_valid;
    assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_score_digit_source.sv
// Directed self-checking bench for score_digit_source: default 16/5 instance plus a 20/5
// instance for the overflow path.
module tb_score_digit_source;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

`ifdef SCORE_LEADING_BLANK_EN
    localparam logic LB = 1'b1;
`else
    localparam logic LB = 1'b0;
`endif

    score_digit_source_if #(.BIN_WIDTH(16), .DIGITS(5)) if_a ();
    score_digit_source_if #(.BIN_WIDTH(20), .DIGITS(5)) if_b ();

    score_digit_source #(.BIN_WIDTH(16), .DIGITS(5)) u_a (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (if_a)
    );

    score_digit_source #(.BIN_WIDTH(20), .DIGITS(5)) u_b (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rd_a(input string tag, input int sel, input logic [3:0] d, input logic b);
        if_a.digit_sel = 4'(sel);
        #1;
        chk($sformatf("%s_d%0d", tag, sel), 32'(if_a.digit_out), 32'(d));
        chk($sformatf("%s_b%0d", tag, sel), 32'(if_a.digit_blank), 32'(b));
    endtask

    task automatic rd_b(input string tag, input int sel, input logic [3:0] d);
        if_b.digit_sel = 4'(sel);
        #1;
        chk($sformatf("%s_d%0d", tag, sel), 32'(if_b.digit_out), 32'(d));
    endtask

    initial begin
        logic early_done;
        logic [3:0] exp_d [5];

        rst_n = 1'b0;
        if_a.score_in = '0; if_a.load = 1'b0; if_a.digit_sel = '0;
        if_b.score_in = '0; if_b.load = 1'b0; if_b.digit_sel = '0;
        tickn(2);

        // Reset state
        chk("rst_busy", 32'(if_a.busy), 0);
        chk("rst_valid", 32'(if_a.valid), 0);
        chk("rst_done", 32'(if_a.done), 0);
        chk("rst_ovf", 32'(if_a.overflow), 0);
        chk("rst_digit", 32'(if_a.digit_out), 0);
        rst_n = 1'b1;
        tick();

        // Basic conversion of 12345: done visible after the 17th edge past the load edge
        if_a.score_in = 16'd12345; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        chk("basic_busy", 32'(if_a.busy), 1);
        early_done = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (if_a.done) early_done = 1'b1;
        end
        chk("basic_early_done", 32'(early_done), 0);
        chk("basic_valid_pre", 32'(if_a.valid), 0);
        tick();
        chk("basic_done", 32'(if_a.done), 1);
        chk("basic_valid", 32'(if_a.valid), 1);
        chk("basic_busy_low", 32'(if_a.busy), 0);
        chk("basic_ovf", 32'(if_a.overflow), 0);
        tick();
        chk("basic_done_fall", 32'(if_a.done), 0);
        exp_d = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 5; i++) rd_a("basic", i, exp_d[i], 1'b0);
        $display("xact: score=12345 committed");

        // Busy/pending: 100 at E0, 7 at E5, 9999 at E8
        if_a.score_in = 16'd100; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        tickn(4);
        if_a.score_in = 16'd7; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        tickn(2);
        if_a.score_in = 16'd9999; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        tickn(9);
        chk("pend_done1", 32'(if_a.done), 1);
        rd_a("pend_100", 2, 4'd1, 1'b0);
        rd_a("pend_100", 0, 4'd0, 1'b0);
        $display("xact: score=100 committed");
        tick();
        chk("pend_restart_busy", 32'(if_a.busy), 1);
        tickn(8);
        rd_a("pend_hold", 2, 4'd1, 1'b0);
        chk("pend_hold_done", 32'(if_a.done), 0);
        tickn(9);
        chk("pend_done2", 32'(if_a.done), 1);
        exp_d = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd0};
        for (int i = 0; i < 4; i++) rd_a("pend_9999", i, exp_d[i], 1'b0);
        rd_a("pend_9999", 4, 4'd0, LB);
        $display("xact: score=9999 committed");
        tickn(2);
        chk("pend_no_third", 32'(if_a.busy), 0);

        // Reset mid-SHIFT of 500
        if_a.digit_sel = 4'd1;
        if_a.score_in = 16'd500; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        tickn(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(if_a.busy), 0);
        chk("mrst_valid", 32'(if_a.valid), 0);
        chk("mrst_digit", 32'(if_a.digit_out), 0);
        chk("mrst_ovf", 32'(if_a.overflow), 0);
        tick();
        chk("mrst_done", 32'(if_a.done), 0);
        rst_n = 1'b1;
        tickn(20);
        chk("mrst_no_commit", 32'(if_a.valid), 0);
        $display("xact: score=500 aborted by reset");

        if_a.score_in = 16'd3; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        tickn(17);
        chk("post_rst_done", 32'(if_a.done), 1);
        rd_a("post_rst", 0, 4'd3, 1'b0);
        rd_a("post_rst", 1, 4'd0, LB);
        $display("xact: score=3 committed");

        // Score 0: digit 0 never blanked
        if_a.score_in = 16'd0; if_a.load = 1'b1;
        tick();
        if_a.load = 1'b0;
        tickn(17);
        chk("zero_done", 32'(if_a.done), 1);
        rd_a("zero", 0, 4'd0, 1'b0);
        for (int i = 1; i < 5; i++) rd_a("zero", i, 4'd0, LB);
        $display("xact: score=0 committed");

        // Out-of-range selects
        rd_a("oor", 7, 4'd0, 1'b1);
        rd_a("oor", 5, 4'd0, 1'b1);

        // Overflow on the 20-bit instance
        if_b.score_in = 20'd123456; if_b.load = 1'b1;
        tick();
        if_b.load = 1'b0;
        tickn(21);
        chk("ovf_done", 32'(if_b.done), 1);
        chk("ovf_flag", 32'(if_b.overflow), 1);
        for (int i = 0; i < 5; i++) rd_b("ovf", i, 4'd9);
        $display("xact: score=123456 committed (20-bit)");

        if_b.score_in = 20'd42; if_b.load = 1'b1;
        tick();
        if_b.load = 1'b0;
        tickn(21);
        chk("ovf_clear_done", 32'(if_b.done), 1);
        chk("ovf_clear", 32'(if_b.overflow), 0);
        exp_d = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 5; i++) rd_b("ovf42", i, exp_d[i]);
        $display("xact: score=42 committed (20-bit)");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
